// File: rtl/mux_five_to_one_seq_pkg.sv
// -----------------------------------------------------------------------------
// mux5_pkg
// Shared types for the sequential 5-to-1 collector (mux_five_to_one_seq).
//   state_t        : controller states (IDLE, SEND)
//   op_e           : 3-bit word tags, OP_A (000) .. OP_E (100)
//   pick_t         : result of an unmasked-index search
//   find_unmasked  : lowest unmasked index at or above a start index
// -----------------------------------------------------------------------------
package mux5_pkg;

    localparam int N_WORDS = 5;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    typedef enum logic [2:0] {
        OP_A = 3'b000,
        OP_B = 3'b001,
        OP_C = 3'b010,
        OP_D = 3'b011,
        OP_E = 3'b100
    } op_e;

    typedef struct packed {
        logic found;
        op_e  idx;
    } pick_t;

    // Lowest index i >= from whose mask bit is clear. Scanning downwards lets
    // the lowest hit overwrite any higher one without an early exit.
    function automatic pick_t find_unmasked(input logic [2:0]         from,
                                            input logic [N_WORDS-1:0] mask);
        pick_t r;
        r.found = 1'b0;
        r.idx   = OP_A;
        for (int i = N_WORDS - 1; i >= 0; i--) begin
            if (3'(i) >= from && !mask[i]) begin
                r.found = 1'b1;
                r.idx   = op_e'(3'(i));
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mux_five_to_one_seq_if.sv
// -----------------------------------------------------------------------------
// mux_five_to_one_seq_if
// Output stream of the 5-to-1 collector towards its single consumer.
//   saida  : current word (WIDTH bits)
//   op     : 3-bit tag of the current word (000 a .. 100 e)
//   valid  : saida/op hold a word to transfer
//   ready  : consumer accepts; a transfer is valid && ready at a rising edge
// Modports: master = collector side, slave = consumer side.
// -----------------------------------------------------------------------------
interface mux_five_to_one_seq_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] saida;
    logic [2:0]       op;
    logic             valid;
    logic             ready;

    modport master (
        output saida,
        output op,
        output valid,
        input  ready
    );

    modport slave (
        input  saida,
        input  op,
        input  valid,
        output ready
    );
endinterface

// File: rtl/mux_five_to_one_seq_next_idx_sel.sv
// -----------------------------------------------------------------------------
// next_idx_sel
// Combinational successor of the current word index.
//   idx_i   : index of the word being presented (0..4)
//   mask_i  : latched skip mask, bit i=1 skips word i (MUX5_MASK_EN only)
//   next_o  : index of the next word to present
//   last_o  : idx_i is the final word of the sequence
// Optional feature macro: MUX5_MASK_EN. Without it the successor is idx+1 and
// the last word is always index 4.
// -----------------------------------------------------------------------------
module next_idx_sel
    import mux5_pkg::*;
(
    input  op_e                idx_i,
`ifdef MUX5_MASK_EN
    input  logic [N_WORDS-1:0] mask_i,
`endif
    output op_e                next_o,
    output logic               last_o
);

`ifdef MUX5_MASK_EN
    pick_t pick;

    // idx_i never exceeds 4, so idx_i+1 fits in 3 bits; from=5 finds nothing.
    always_comb begin
        pick   = find_unmasked(idx_i + 3'd1, mask_i);
        next_o = pick.found ? pick.idx : idx_i;
        last_o = !pick.found;
    end
`else
    assign last_o = (idx_i == OP_E);
    assign next_o = last_o ? idx_i : op_e'(idx_i + 3'd1);
`endif

endmodule

// File: rtl/mux_five_to_one_seq.sv
// -----------------------------------------------------------------------------
// mux_five_to_one_seq
// Sequential 5-to-1 collector: captures a..e on an accepted start, then streams
// them one word per handshake on bus.saida with its tag on bus.op.
//   clock    : rising-edge clock
//   reset_n  : asynchronous active-low reset
//   start    : capture a..e and begin a sequence (honoured only in IDLE)
//   a..e     : source words, sampled on the accepted start edge only
//   mask     : skip mask, bit i=1 skips word i (MUX5_MASK_EN only)
//   busy     : high from the accepted start until the last transfer
//   done     : one-cycle pulse after the last transfer
//   bus      : master side of mux_five_to_one_seq_if (saida, op, valid, ready)
// Optional feature macro: MUX5_MASK_EN (adds mask port and word skipping).
// All outputs come from registers; nothing on the input side reaches them
// combinationally.
// -----------------------------------------------------------------------------
module mux_five_to_one_seq
    import mux5_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [WIDTH-1:0]      a,
    input  logic [WIDTH-1:0]      b,
    input  logic [WIDTH-1:0]      c,
    input  logic [WIDTH-1:0]      d,
    input  logic [WIDTH-1:0]      e,
`ifdef MUX5_MASK_EN
    input  logic [N_WORDS-1:0]    mask,
`endif
    output logic                  busy,
    output logic                  done,
    mux_five_to_one_seq_if.master bus
);

    state_t                         state_q, state_d;
    op_e                            idx_q, idx_d;
    logic [N_WORDS-1:0][WIDTH-1:0]  word_q, word_d;
    logic                           valid_q, valid_d;
    logic                           busy_q, busy_d;
    logic                           done_q, done_d;
    op_e                            nxt_idx;
    logic                           nxt_last;

`ifdef MUX5_MASK_EN
    logic [N_WORDS-1:0]             mask_q, mask_d;
    pick_t                          first;
`endif

    next_idx_sel u_next_idx_sel (
        .idx_i  (idx_q),
`ifdef MUX5_MASK_EN
        .mask_i (mask_q),
`endif
        .next_o (nxt_idx),
        .last_o (nxt_last)
    );

    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path
        // leaves a value unassigned and no latch is inferred.
        state_d = state_q;
        idx_d   = idx_q;
        word_d  = word_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef MUX5_MASK_EN
        mask_d  = mask_q;
        first   = find_unmasked(OP_A, mask);
`endif

        case (state_q)
            IDLE: begin
                if (start) begin
                    word_d = {e, d, c, b, a};
`ifdef MUX5_MASK_EN
                    mask_d = mask;
                    if (first.found) begin
                        idx_d   = first.idx;
                        state_d = SEND;
                        valid_d = 1'b1;
                        busy_d  = 1'b1;
                    end else begin
                        // Everything masked: nothing to send, just signal done.
                        done_d = 1'b1;
                    end
`else
                    idx_d   = OP_A;
                    state_d = SEND;
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
`endif
                end
            end

            SEND: begin
                // valid is always high in SEND, so ready alone marks a transfer.
                if (bus.ready) begin
                    if (nxt_last) begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = nxt_idx;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            idx_q   <= OP_A;
            // NOTE: the word store is reset as well, since saida reads it
            // directly and must be 0 straight out of reset.
            word_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef MUX5_MASK_EN
            mask_q  <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge value of the others, regardless of statement order.
            state_q <= state_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef MUX5_MASK_EN
            mask_q  <= mask_d;
`endif
        end
    end

    assign bus.saida = word_q[idx_q];
    assign bus.op    = idx_q;
    assign bus.valid = valid_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_mux_five_to_one_seq.sv
// -----------------------------------------------------------------------------
// tb_mux_five_to_one_seq
// Self-checking bench for mux_five_to_one_seq: a cycle table of directed
// vectors followed by hand-written sequences for reset, long backpressure and
// (with MUX5_MASK_EN) masked sequences.
// -----------------------------------------------------------------------------
module tb_mux_five_to_one_seq;
    import mux5_pkg::*;

    localparam int WIDTH = 16;

    logic             clock   = 1'b0;
    logic             reset_n = 1'b0;
    logic             start   = 1'b0;
    logic [WIDTH-1:0] a, b, c, d, e;
`ifdef MUX5_MASK_EN
    logic [4:0]       mask;
`endif
    logic             busy, done;

    mux_five_to_one_seq_if #(.WIDTH(WIDTH)) bus ();

    mux_five_to_one_seq #(.WIDTH(WIDTH)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .c       (c),
        .d       (d),
        .e       (e),
`ifdef MUX5_MASK_EN
        .mask    (mask),
`endif
        .busy    (busy),
        .done    (done),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs change and outputs
    // are sampled here, well away from the edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // junk=1 drives all five words to FFFF; otherwise a..e = base+1 .. base+5.
    task automatic set_words(input logic [15:0] base, input logic junk);
        if (junk) begin
            a = 16'hFFFF; b = 16'hFFFF; c = 16'hFFFF; d = 16'hFFFF; e = 16'hFFFF;
        end else begin
            a = base + 16'd1; b = base + 16'd2; c = base + 16'd3;
            d = base + 16'd4; e = base + 16'd5;
        end
    endtask

    task automatic check_out(input string tag, input logic v, input logic [15:0] s,
                             input logic [2:0] o, input logic bz, input logic dn);
        check({tag, " valid"}, 32'(bus.valid), 32'(v));
        check({tag, " busy"},  32'(busy),      32'(bz));
        check({tag, " done"},  32'(done),      32'(dn));
        if (v) begin
            check({tag, " saida"}, 32'(bus.saida), 32'(s));
            check({tag, " op"},    32'(bus.op),    32'(o));
        end
    endtask

    task automatic wait_done(input string tag);
        logic got;
        got = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        check({tag, " done within budget"}, 32'(got), 32'd1);
    endtask

    typedef struct {
        logic        start;
        logic        ready;
        logic        junk;
        logic [15:0] base;
        logic        e_valid;
        logic [15:0] e_saida;
        logic [2:0]  e_op;
        logic        e_busy;
        logic        e_done;
    } vec_t;

    function automatic vec_t mk(input logic st, input logic rd, input logic jk,
                                input logic [15:0] bs, input logic v,
                                input logic [15:0] s, input logic [2:0] o,
                                input logic bz, input logic dn);
        vec_t r;
        r.start = st; r.ready = rd; r.junk = jk; r.base = bs;
        r.e_valid = v; r.e_saida = s; r.e_op = o; r.e_busy = bz; r.e_done = dn;
        return r;
    endfunction

    vec_t vecs [25];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //               st rd jk base      v  saida     op  bz dn
        // Sequence 1: words 1..5, ready always high.
        vecs[0]  = mk(1, 1, 0, 16'h0000, 1, 16'h0001, 0, 1, 0);
        vecs[1]  = mk(0, 1, 0, 16'h0000, 1, 16'h0002, 1, 1, 0);
        vecs[2]  = mk(0, 1, 0, 16'h0000, 1, 16'h0003, 2, 1, 0);
        vecs[3]  = mk(0, 1, 0, 16'h0000, 1, 16'h0004, 3, 1, 0);
        vecs[4]  = mk(0, 1, 0, 16'h0000, 1, 16'h0005, 4, 1, 0);
        vecs[5]  = mk(0, 1, 0, 16'h0000, 0, 16'h0000, 0, 0, 1);
        vecs[6]  = mk(0, 1, 0, 16'h0000, 0, 16'h0000, 0, 0, 0);
        // Sequence 2: toggling ready, start pulses with FFFF words while busy.
        vecs[7]  = mk(1, 0, 0, 16'h0010, 1, 16'h0011, 0, 1, 0);
        vecs[8]  = mk(1, 0, 1, 16'h0010, 1, 16'h0011, 0, 1, 0);
        vecs[9]  = mk(1, 1, 1, 16'h0010, 1, 16'h0012, 1, 1, 0);
        vecs[10] = mk(0, 0, 1, 16'h0010, 1, 16'h0012, 1, 1, 0);
        vecs[11] = mk(0, 0, 1, 16'h0010, 1, 16'h0012, 1, 1, 0);
        vecs[12] = mk(0, 1, 1, 16'h0010, 1, 16'h0013, 2, 1, 0);
        vecs[13] = mk(1, 1, 1, 16'h0010, 1, 16'h0014, 3, 1, 0);
        vecs[14] = mk(0, 0, 1, 16'h0010, 1, 16'h0014, 3, 1, 0);
        vecs[15] = mk(0, 1, 1, 16'h0010, 1, 16'h0015, 4, 1, 0);
        vecs[16] = mk(0, 0, 1, 16'h0010, 1, 16'h0015, 4, 1, 0);
        vecs[17] = mk(0, 1, 1, 16'h0010, 0, 16'h0000, 0, 0, 1);
        // Sequence 3: start driven during the done cycle is accepted.
        vecs[18] = mk(1, 1, 0, 16'h0020, 1, 16'h0021, 0, 1, 0);
        vecs[19] = mk(0, 1, 0, 16'h0020, 1, 16'h0022, 1, 1, 0);
        vecs[20] = mk(0, 1, 0, 16'h0020, 1, 16'h0023, 2, 1, 0);
        vecs[21] = mk(0, 1, 0, 16'h0020, 1, 16'h0024, 3, 1, 0);
        vecs[22] = mk(0, 1, 0, 16'h0020, 1, 16'h0025, 4, 1, 0);
        vecs[23] = mk(0, 1, 0, 16'h0020, 0, 16'h0000, 0, 0, 1);
        vecs[24] = mk(0, 1, 0, 16'h0020, 0, 16'h0000, 0, 0, 0);

        bus.ready = 1'b0;
        set_words(16'h0000, 1'b0);
`ifdef MUX5_MASK_EN
        mask = 5'b00000;
`endif

        // Reset state while reset_n is held low.
        #12;
        check_out("reset", 1'b0, 16'h0000, 3'd0, 1'b0, 1'b0);
        check("reset saida", 32'(bus.saida), 32'd0);
        check("reset op",    32'(bus.op),    32'd0);
        tick();
        reset_n = 1'b1;
        tick();
        check_out("idle after reset", 1'b0, 16'h0000, 3'd0, 1'b0, 1'b0);

        // Cycle table.
        for (int i = 0; i < 25; i++) begin
            start     = vecs[i].start;
            bus.ready = vecs[i].ready;
            set_words(vecs[i].base, vecs[i].junk);
            tick();
            check_out($sformatf("row%0d", i), vecs[i].e_valid, vecs[i].e_saida,
                      vecs[i].e_op, vecs[i].e_busy, vecs[i].e_done);
        end
        start = 1'b0;

        // Ready low for 10 cycles with valid: nothing moves.
        set_words(16'h0040, 1'b0);
        start     = 1'b1;
        bus.ready = 1'b0;
        tick();
        start = 1'b0;
        set_words(16'h0000, 1'b1);
        check_out("hold start", 1'b1, 16'h0041, 3'd0, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            tick();
            check_out($sformatf("hold%0d", i), 1'b1, 16'h0041, 3'd0, 1'b1, 1'b0);
        end
        bus.ready = 1'b1;
        tick();
        check_out("hold release", 1'b1, 16'h0042, 3'd1, 1'b1, 1'b0);
        wait_done("hold drain");
        tick();

        // Asynchronous reset in the middle of a sequence.
        set_words(16'h0050, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check_out("pre-abort", 1'b1, 16'h0052, 3'd1, 1'b1, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        check_out("abort", 1'b0, 16'h0000, 3'd0, 1'b0, 1'b0);
        check("abort saida", 32'(bus.saida), 32'd0);
        check("abort op",    32'(bus.op),    32'd0);
        tick();
        reset_n = 1'b1;
        tick();
        check_out("after abort", 1'b0, 16'h0000, 3'd0, 1'b0, 1'b0);
        set_words(16'h0060, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check_out("restart", 1'b1, 16'h0061, 3'd0, 1'b1, 1'b0);
        wait_done("restart drain");
        tick();

`ifdef MUX5_MASK_EN
        // Words b and d skipped, no bubbles.
        set_words(16'h0030, 1'b0);
        mask      = 5'b01010;
        bus.ready = 1'b1;
        start     = 1'b1;
        tick();
        start = 1'b0;
        mask  = 5'b00000;
        check_out("mask01010 w0", 1'b1, 16'h0031, 3'd0, 1'b1, 1'b0);
        tick();
        check_out("mask01010 w2", 1'b1, 16'h0033, 3'd2, 1'b1, 1'b0);
        tick();
        check_out("mask01010 w4", 1'b1, 16'h0035, 3'd4, 1'b1, 1'b0);
        tick();
        check_out("mask01010 end", 1'b0, 16'h0000, 3'd0, 1'b0, 1'b1);
        tick();

        // Everything masked: done one cycle after start, no valid, no busy.
        mask  = 5'b11111;
        start = 1'b1;
        tick();
        start = 1'b0;
        mask  = 5'b00000;
        check_out("mask11111 done", 1'b0, 16'h0000, 3'd0, 1'b0, 1'b1);
        tick();
        check_out("mask11111 idle", 1'b0, 16'h0000, 3'd0, 1'b0, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
